// File: rtl/issue_replay_buffer.sv
// Issue-side replay buffer: issues the oldest hazard-free slots into ID/EX
// and replays rolled-back younger slots at slot 0 on the next cycle.
package issue_pkg;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [4:0]  ZERO_REG = 5'd0;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  dest_reg_idx;
        logic        rd_mem;
        logic        wr_mem;
        logic        valid;
    } ID_EX_PACKET;

    localparam ID_EX_PACKET NOP_PACKET = '{
        npc:          32'd0,
        pc:           32'd0,
        inst:         NOP,
        dest_reg_idx: ZERO_REG,
        rd_mem:       1'b0,
        wr_mem:       1'b0,
        valid:        1'b0
    };

endpackage

module issue_replay_buffer
    import issue_pkg::*;
#(
    parameter int WAYS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        squash,
    input  logic        in_valid,
    input  ID_EX_PACKET id_packet_in_0,
    input  ID_EX_PACKET id_packet_in_1,
    input  ID_EX_PACKET id_packet_in_2,
    output logic        in_ready,
    output ID_EX_PACKET id_packet_out_0,
    output ID_EX_PACKET id_packet_out_1,
    output ID_EX_PACKET id_packet_out_2,
    input  logic [1:0]  rollback,
    output ID_EX_PACKET ex_packet_0,
    output ID_EX_PACKET ex_packet_1,
    output ID_EX_PACKET ex_packet_2,
    output logic [31:0] stall_count
);

    if (WAYS != 3) begin : g_bad_ways
        $error("issue_replay_buffer: WAYS must be 3");
    end

    ID_EX_PACKET pend    [3];
    ID_EX_PACKET pend_nx [3];
    ID_EX_PACKET in_pkt  [3];
    ID_EX_PACKET cur     [3];
    ID_EX_PACKET ex_q    [3];
    logic [1:0]  pend_cnt;
    logic [1:0]  cnt_nx;
    logic [1:0]  keep;
    logic [2:0]  issue;
    logic        any_valid;

    assign in_pkt[0] = id_packet_in_0;
    assign in_pkt[1] = id_packet_in_1;
    assign in_pkt[2] = id_packet_in_2;

    assign in_ready = (pend_cnt == 2'd0);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cur[i] = NOP_PACKET;
            if (pend_cnt != 2'd0) begin
                if (2'(i) < pend_cnt)
                    cur[i] = pend[i];
            end else if (in_valid) begin
                cur[i] = in_pkt[i];
            end
        end
    end

    // Held slots are compacted so interior bubbles never occupy pend entries.
    always_comb begin
        any_valid = cur[0].valid | cur[1].valid | cur[2].valid;
        keep      = any_valid ? (2'd3 - rollback) : 2'd3;
        cnt_nx    = 2'd0;
        issue     = 3'b000;
        for (int i = 0; i < 3; i++)
            pend_nx[i] = NOP_PACKET;
        for (int i = 0; i < 3; i++) begin
            if (cur[i].valid) begin
                if (2'(i) < keep) begin
                    issue[i] = 1'b1;
                end else begin
                    pend_nx[cnt_nx] = cur[i];
                    cnt_nx          = cnt_nx + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_cnt    <= 2'd0;
            stall_count <= 32'd0;
            for (int i = 0; i < 3; i++) begin
                pend[i] <= NOP_PACKET;
                ex_q[i] <= NOP_PACKET;
            end
        end else begin
            if (in_valid && !in_ready && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
            if (squash) begin
                pend_cnt <= 2'd0;
                for (int i = 0; i < 3; i++) begin
                    pend[i] <= NOP_PACKET;
                    ex_q[i] <= NOP_PACKET;
                end
            end else begin
                pend_cnt <= cnt_nx;
                for (int i = 0; i < 3; i++) begin
                    pend[i] <= pend_nx[i];
                    ex_q[i] <= issue[i] ? cur[i] : NOP_PACKET;
                end
            end
        end
    end

    assign id_packet_out_0 = cur[0];
    assign id_packet_out_1 = cur[1];
    assign id_packet_out_2 = cur[2];

    assign ex_packet_0 = ex_q[0];
    assign ex_packet_1 = ex_q[1];
    assign ex_packet_2 = ex_q[2];

endmodule

// File: tb/tb_issue_replay_buffer.sv
// Directed table-driven bench for issue_replay_buffer.
module tb_issue_replay_buffer;
    import issue_pkg::*;

    localparam logic [31:0] A = 32'h0010_8093;
    localparam logic [31:0] B = 32'h0021_0113;
    localparam logic [31:0] C = 32'h0031_8193;
    localparam logic [31:0] D = 32'h0010_8113;
    localparam logic [31:0] Z = 32'h0000_0000;
    localparam int NV = 25;

    typedef struct packed {
        logic             sq;
        logic             iv;
        logic [1:0]       rb;
        logic [2:0][31:0] in;
        logic             rdy;
        logic [1:0]       pc;
        logic [2:0][31:0] out;
        logic [2:0][31:0] ex;
        logic [31:0]      stall;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        squash;
    logic        in_valid;
    logic [1:0]  rollback;
    logic        in_ready;
    logic [31:0] stall_count;
    ID_EX_PACKET pin  [3];
    ID_EX_PACKET pout [3];
    ID_EX_PACKET pex  [3];

    int   ncmp  = 0;
    int   nfail = 0;
    vec_t vt [NV];

    always #5 clock = ~clock;

    issue_replay_buffer #(.WAYS(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .squash         (squash),
        .in_valid       (in_valid),
        .id_packet_in_0 (pin[0]),
        .id_packet_in_1 (pin[1]),
        .id_packet_in_2 (pin[2]),
        .in_ready       (in_ready),
        .id_packet_out_0(pout[0]),
        .id_packet_out_1(pout[1]),
        .id_packet_out_2(pout[2]),
        .rollback       (rollback),
        .ex_packet_0    (pex[0]),
        .ex_packet_1    (pex[1]),
        .ex_packet_2    (pex[2]),
        .stall_count    (stall_count)
    );

    // Word 0 stands for a NOP slot; other fields are derived from the word.
    function automatic ID_EX_PACKET mk(input logic [31:0] w);
        ID_EX_PACKET p;
        p = NOP_PACKET;
        if (w != 32'd0) begin
            p.valid        = 1'b1;
            p.inst         = w;
            p.dest_reg_idx = w[11:7];
            p.pc           = {16'h0, w[15:0]};
            p.npc          = {16'h0, w[15:0]} + 32'd4;
            p.rd_mem       = w[20];
            p.wr_mem       = w[21];
        end
        return p;
    endfunction

    function automatic vec_t mkv(
        input logic sq, input logic iv, input logic [1:0] rb,
        input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
        input logic rdy, input logic [1:0] pc,
        input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
        input logic [31:0] st);
        vec_t v;
        v.sq = sq; v.iv = iv; v.rb = rb;
        v.in[0] = i0; v.in[1] = i1; v.in[2] = i2;
        v.rdy = rdy; v.pc = pc;
        v.out[0] = o0; v.out[1] = o1; v.out[2] = o2;
        v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2;
        v.stall = st;
        return v;
    endfunction

    task automatic chk_pkt(input string nm, input int v,
                           input ID_EX_PACKET a, input ID_EX_PACKET e);
        ncmp++;
        if (a !== e) begin
            nfail++;
            $display("FAIL v%0d %s: got %h want %h", v, nm, a, e);
        end
    endtask

    task automatic chk_val(input string nm, input int v,
                           input logic [31:0] a, input logic [31:0] e);
        ncmp++;
        if (a !== e) begin
            nfail++;
            $display("FAIL v%0d %s: got %h want %h", v, nm, a, e);
        end
    endtask

    initial begin
        // sq iv rb  in0..2   rdy pc out0..2  ex0..2  stall
        vt[0]  = mkv(0,0,0, Z,Z,Z, 1,0, Z,Z,Z, Z,Z,Z, 0);
        vt[1]  = mkv(0,1,0, A,B,C, 1,0, A,B,C, A,B,C, 0);
        vt[2]  = mkv(0,1,2, A,D,C, 1,0, A,D,C, A,Z,Z, 0);
        vt[3]  = mkv(0,1,0, A,B,C, 0,2, D,C,Z, D,C,Z, 1);
        vt[4]  = mkv(0,0,0, Z,Z,Z, 1,0, Z,Z,Z, Z,Z,Z, 1);
        vt[5]  = mkv(0,1,3, A,B,C, 1,0, A,B,C, Z,Z,Z, 1);
        vt[6]  = mkv(0,1,3, A,B,C, 0,3, A,B,C, Z,Z,Z, 2);
        vt[7]  = mkv(0,1,0, A,B,C, 0,3, A,B,C, A,B,C, 3);
        vt[8]  = mkv(0,0,0, Z,Z,Z, 1,0, Z,Z,Z, Z,Z,Z, 3);
        vt[9]  = mkv(0,1,2, A,D,C, 1,0, A,D,C, A,Z,Z, 3);
        vt[10] = mkv(0,0,2, Z,Z,Z, 0,2, D,C,Z, D,Z,Z, 3);
        vt[11] = mkv(0,0,0, Z,Z,Z, 0,1, C,Z,Z, C,Z,Z, 3);
        vt[12] = mkv(0,0,0, Z,Z,Z, 1,0, Z,Z,Z, Z,Z,Z, 3);
        vt[13] = mkv(0,1,2, A,D,C, 1,0, A,D,C, A,Z,Z, 3);
        vt[14] = mkv(1,0,0, Z,Z,Z, 0,2, D,C,Z, Z,Z,Z, 3);
        vt[15] = mkv(0,0,0, Z,Z,Z, 1,0, Z,Z,Z, Z,Z,Z, 3);
        vt[16] = mkv(0,0,3, Z,Z,Z, 1,0, Z,Z,Z, Z,Z,Z, 3);
        vt[17] = mkv(0,0,0, Z,Z,Z, 1,0, Z,Z,Z, Z,Z,Z, 3);
        vt[18] = mkv(0,1,3, A,Z,C, 1,0, A,Z,C, Z,Z,Z, 3);
        vt[19] = mkv(0,0,0, Z,Z,Z, 0,2, A,C,Z, A,C,Z, 3);
        vt[20] = mkv(0,0,0, Z,Z,Z, 1,0, Z,Z,Z, Z,Z,Z, 3);
        vt[21] = mkv(0,1,1, A,Z,C, 1,0, A,Z,C, A,Z,Z, 3);
        vt[22] = mkv(0,0,0, Z,Z,Z, 0,1, C,Z,Z, C,Z,Z, 3);
        vt[23] = mkv(1,1,0, A,B,C, 1,0, A,B,C, Z,Z,Z, 3);
        vt[24] = mkv(0,0,0, Z,Z,Z, 1,0, Z,Z,Z, Z,Z,Z, 3);

        reset    = 1'b1;
        squash   = 1'b0;
        in_valid = 1'b0;
        rollback = 2'd0;
        for (int k = 0; k < 3; k++) pin[k] = NOP_PACKET;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            if (v != 0) @(negedge clock);
            squash   = vt[v].sq;
            in_valid = vt[v].iv;
            rollback = vt[v].rb;
            for (int k = 0; k < 3; k++) pin[k] = mk(vt[v].in[k]);
            #1;
            chk_val("in_ready", v, {31'd0, in_ready}, {31'd0, vt[v].rdy});
            chk_val("pend_cnt", v, {30'd0, dut.pend_cnt}, {30'd0, vt[v].pc});
            for (int k = 0; k < 3; k++)
                chk_pkt($sformatf("out%0d", k), v, pout[k], mk(vt[v].out[k]));
            @(posedge clock);
            #1;
            for (int k = 0; k < 3; k++)
                chk_pkt($sformatf("ex%0d", k), v, pex[k], mk(vt[v].ex[k]));
            chk_val("stall", v, stall_count, vt[v].stall);
        end

        // Reset while the whole group is held.
        @(negedge clock);
        squash   = 1'b0;
        in_valid = 1'b1;
        rollback = 2'd3;
        pin[0] = mk(A); pin[1] = mk(B); pin[2] = mk(C);
        @(posedge clock);
        #1;
        chk_val("rst_pre_pend", 100, {30'd0, dut.pend_cnt}, 32'd3);
        chk_val("rst_pre_rdy", 100, {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        reset    = 1'b1;
        rollback = 2'd0;
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++)
            chk_pkt($sformatf("rst_ex%0d", k), 101, pex[k], NOP_PACKET);
        chk_val("rst_stall", 101, stall_count, 32'd0);
        chk_val("rst_rdy", 101, {31'd0, in_ready}, 32'd1);
        chk_val("rst_pend", 101, {30'd0, dut.pend_cnt}, 32'd0);
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            chk_pkt($sformatf("rst_out%0d", k), 102, pout[k], NOP_PACKET);
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++)
            chk_pkt($sformatf("rst_post_ex%0d", k), 103, pex[k], NOP_PACKET);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/issue_replay_buffer.md
# issue_replay_buffer

Issue-side consumer of the hazard detection unit's `rollback` output in the 3-way superscalar pipeline. Each cycle it presents one group of up to three decoded `ID_EX_PACKET`s to the detection unit. It registers the oldest issuable slots into the ID/EX pipeline register and holds the rolled-back younger slots. It replays those held slots at slot 0 on the next cycle, back-pressuring decode while a replay is pending.

## Interface
- `WAYS`, 3, issue width; fixed at 3 and checked by an elaboration assertion.
- `clock` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `squash` in 1: branch-mispredict flush.
- `in_valid` in 1: decode group valid.
- `id_packet_in_0..2` in `ID_EX_PACKET`: decoded group, slot 0 oldest.
- `in_ready` out 1: buffer accepts the decode group this cycle.
- `id_packet_out_0..2` out `ID_EX_PACKET`: current group, driven to the detection unit.
- `rollback` in 2: from the detection unit, computed on `id_packet_out_*`; the number of youngest slots (0..3) that must not issue.
- `ex_packet_0..2` out `ID_EX_PACKET`: registered ID/EX stage contents.
- `stall_count` out 32: saturating count of decode-stall cycles.

## Operation
- State:
  - `pend[0..2]`: held packets.
  - `pend_cnt`: 0..3, the number of held packets.
  - `stall_count`.
- `in_ready = (pend_cnt == 0)`. This is a combinational function of registered state only.
- Current group selection:
  - If `pend_cnt > 0`: slots `0..pend_cnt-1` are `pend[*]`, and the remaining slots are NOP.
  - Otherwise, if `in_valid`: the current group is `id_packet_in_*`.
  - Otherwise: all slots are NOP.
- NOP packet fields: `valid=0`, `inst=NOP`, `dest_reg_idx=ZERO_REG`, `rd_mem=0`, `wr_mem=0`, and all other fields 0.
- Issue rule: slot `i` issues iff `valid_i && i < 3 - rollback`.
- Held slots: valid slots with `i >= 3 - rollback`. Held slots are always the contiguous youngest slots.
- Next pending state:
  - Held slots shift down by `3 - rollback`, preserving order.
  - `pend_cnt` becomes the number of valid held slots.
  - Entries above `pend_cnt` are cleared to NOP.
- `rollback` is ignored (treated as 0) when the current group has no valid slot.
- ID/EX register update:
  - `ex_packet_i` is loaded with the current slot `i` if it issues, and with NOP otherwise.
  - Slot position is preserved, so forwarding-select indices stay aligned.
- `stall_count` increments when `in_valid && !in_ready`, and saturates at `32'hFFFF_FFFF`.
- Squash, and reset:
  - `pend_cnt` is set to 0 and all `pend` entries to NOP.
  - All `ex_packet_*` are set to NOP.
  - The decode group presented in that cycle is dropped.
  - Only reset clears `stall_count`; squash does not.
- Squash has priority over `rollback` and over issue in the same cycle.

## Timing
- Reset values:
  - `ex_packet_0..2` = NOP.
  - `pend_cnt = 0`, so `in_ready = 1`.
  - `id_packet_out_*` is all NOP when `in_valid = 0`.
  - `stall_count = 0`.
- An issued instruction appears on `ex_packet_i` exactly 1 cycle after it is presented on `id_packet_out_i`.
- A held instruction appears on `id_packet_out_0..` in the next cycle. It is re-evaluated every cycle until it issues.
- `rollback = 3` on a group (load-use on slot 0) holds the entire group. The group is presented again unchanged, and `ex_packet_*` is all NOP.
- Repeated rollbacks are legal indefinitely. Forward progress is the detection unit's responsibility.
- `in_ready` drops on the cycle after a partial or total hold. It rises on the cycle after `pend_cnt` returns to 0. Every replay therefore costs at least 1 decode bubble.
- Squash and reset mid-replay:
  - `in_ready = 1` and the outputs are NOP on the following cycle.
  - No held instruction reaches EX after the squash edge.
- A group with interior invalid slots (e.g. slot 1 NOP) follows the same rule. Only valid held slots count toward `pend_cnt`, and they are shifted down contiguously.

## Test plan
- No hazard:
  - Stimulus: group `00108093`/`00210113`/`00318193` with `in_valid=1` and `rollback=0`.
  - Required response: the next cycle `ex_packet_0..2.inst` equals the same three words, all valid; `in_ready` stays 1.
- Partial hold:
  - Stimulus: group `00108093`/`00108113`/`00318193` with `rollback=2`.
  - Required response, cycle +1:
    - `ex_packet_0 = 00108093`, slots 1 and 2 NOP.
    - `id_packet_out_0 = 00108113`, `id_packet_out_1 = 00318193`, `id_packet_out_2` NOP.
    - `in_ready = 0`.
  - Then, with `rollback=0`:
    - `ex_packet_0/1` hold those two words.
    - `in_ready = 1` on cycle +2.
- Total hold:
  - Stimulus: group `00108093`/`00210113`/`00318193` with `rollback=3` for 2 cycles, then 0.
  - Required response:
    - `ex_packet_*` is NOP for 2 cycles, then carries the full group.
    - `stall_count` advances by 2 with `in_valid` held high.
- Replay with a second rollback:
  - Stimulus: pend = `00108113`/`00318193` with `rollback=2` (slot 0 issues, slot 1 held).
  - Required response: the next cycle `id_packet_out_0 = 00318193` and `pend_cnt = 1`.
- Squash mid-replay:
  - Stimulus: `pend_cnt = 2` and `squash = 1` with `rollback=0`.
  - Required response: the next cycle `ex_packet_*` is all NOP, `pend_cnt = 0`, `in_ready = 1`, and `stall_count` is unchanged.
- Reset mid-replay:
  - Stimulus: `reset` asserted with `pend_cnt = 3`.
  - Required response: all outputs return to their reset values on the next edge, and `stall_count = 0`.
